jk_cmd_sequencer: RTL

- Upstream driver for the negedge-clocked JK flip-flop stage.
- Accepts high-level commands (HOLD, RESET, SET, TOGGLE) with a repeat count over a valid/ready handshake.
- Drives J/K from posedge-registered outputs, so they are stable at every flip-flop negedge.
- Keeps a reference model of the expected Q, compares it against the flip-flop's Q fed back, and flags any divergence.

---
 rtl/jk_pkg.sv | 10 +
 rtl/jk_cmd_sequencer_if.sv | 10 +
 rtl/jk_expect.sv | 56 +++++
 rtl/jk_cmd_sequencer.sv | 83 ++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared op encodings and sequencer states for the JK flip-flop command path.
// An op is the {J,K} pair it drives onto the flip-flop.
package jk_pkg;
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;
endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake bundle: the master issues op/count, the sequencer answers with ready.
interface jk_cmd_sequencer_if #(parameter int CW = 8);
  logic          CMD_VALID;
  logic [1:0]    CMD_OP;
  logic [CW-1:0] CMD_CNT;
  logic          CMD_READY;

  modport master (output CMD_VALID, CMD_OP, CMD_CNT, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_OP, CMD_CNT, output CMD_READY);
endinterface

// File: rtl/jk_expect.sv
// Reference model of the JK flip-flop Q, advanced once per applied negedge, with a sticky
// divergence flag against the fed-back Q.
module jk_expect
  import jk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic       apply,
  input  logic       q_fb,
  input  logic       clr_err,
  output logic       exp_q,
  output logic       exp_valid,
  output logic       mismatch
);
  logic exp_q_nxt;
  logic exp_valid_nxt;
  logic mis_set;

  always_comb begin
    exp_q_nxt     = exp_q;
    exp_valid_nxt = exp_valid;
    if (apply) begin
      case (op)
        OP_RESET: begin
          exp_q_nxt     = 1'b0;
          exp_valid_nxt = 1'b1;
        end
        OP_SET: begin
          exp_q_nxt     = 1'b1;
          exp_valid_nxt = 1'b1;
        end
        OP_TOGGLE: exp_q_nxt = ~exp_q;
        default:   exp_q_nxt = exp_q;
      endcase
    end
  end

  // A compare is only meaningful once the model has been anchored by a SET or RESET.
  assign mis_set = apply && exp_valid_nxt && (q_fb != exp_q_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      exp_q     <= exp_q_nxt;
      exp_valid <= exp_valid_nxt;
      if (mis_set)
        mismatch <= 1'b1;
      else if (clr_err)
        mismatch <= 1'b0;
    end
  end
endmodule

// File: rtl/jk_cmd_sequencer.sv
// Turns HOLD/RESET/SET/TOGGLE commands with a repeat count into posedge-registered J/K
// drive for a negedge flip-flop, checking its Q against a reference model.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic                CLK,
  input  logic                RSTn,
  jk_cmd_sequencer_if.slave   cmd,
  output logic                J,
  output logic                K,
  input  logic                Q_FB,
  input  logic                CLR_ERR,
  output logic                BUSY,
  output logic                DONE,
  output logic                EXP_Q,
  output logic                EXP_VALID,
  output logic                MISMATCH
);
  state_t        state, state_nxt;
  logic [CW-1:0] rem, rem_nxt;
  logic          j_nxt, k_nxt, done_nxt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_IDLE;
      rem   <= '0;
      J     <= 1'b0;
      K     <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      J     <= j_nxt;
      K     <= k_nxt;
      DONE  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    j_nxt     = J;
    k_nxt     = K;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd.CMD_VALID) begin
          {j_nxt, k_nxt} = cmd.CMD_OP;
          rem_nxt        = (cmd.CMD_CNT == '0) ? CW'(1) : cmd.CMD_CNT;
          state_nxt      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Each posedge here retires the one negedge that saw the current J/K.
        rem_nxt = rem - CW'(1);
        if (rem == CW'(1)) begin
          j_nxt     = 1'b0;
          k_nxt     = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd.CMD_READY = (state == ST_IDLE);
  assign BUSY          = (state == ST_ISSUE);

  jk_expect u_expect (
    .clk       (CLK),
    .rst_n     (RSTn),
    .op        ({J, K}),
    .apply     (BUSY),
    .q_fb      (Q_FB),
    .clr_err   (CLR_ERR),
    .exp_q     (EXP_Q),
    .exp_valid (EXP_VALID),
    .mismatch  (MISMATCH)
  );
endmodule
